// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 opcode constants, canonical NOP and fetch FSM state encoding
package riscv_pkg;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, FLUSH} fetch_state_e;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with reset value, +4 step and word-aligned redirect load
module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] target,
  input  logic        inc,
  output logic [31:0] pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else if (load) pc <= {target[31:2], 2'b00};
    else if (inc) pc <= pc + 32'd4;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch FSM feeding decode with a registered instr/pc pair
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [6:0]  opcode,
  output logic [31:0] pc_out
);
  import riscv_pkg::*;
  fetch_state_e state, state_nx;
  logic [31:0] pc;
  logic take;
  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst_n(rst_n),
    .load(redirect_valid),
    .target(redirect_pc),
    .inc(state == HOLD && instr_ready),
    .pc(pc)
  );
  // a redirect in ISSUE suppresses the request so no stale fetch is ever left in flight
  assign imem_req  = rst_n && state == ISSUE && !redirect_valid;
  assign imem_addr = pc;
  assign take      = state == WAIT && imem_valid && !redirect_valid;
  assign opcode    = instr[6:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ISSUE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      ISSUE: state_nx = redirect_valid ? ISSUE : WAIT;
      WAIT:  state_nx = redirect_valid ? (imem_valid ? ISSUE : FLUSH) : (imem_valid ? HOLD : WAIT);
      HOLD:  state_nx = (redirect_valid || instr_ready) ? ISSUE : HOLD;
      FLUSH: state_nx = imem_valid ? ISSUE : FLUSH;
    endcase
  end
  // instr is valid exactly while in HOLD; any other state shows the NOP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      pc_out      <= RESET_PC;
    end else begin
      instr       <= take ? imem_rdata : (state_nx == HOLD ? instr : NOP_INSTR);
      instr_valid <= state_nx == HOLD;
      pc_out      <= take ? pc : pc_out;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, instruction word held on instr while no fetched instruction is valid.
REQ-003 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: imem_req  output  1  fetch request strobe to instruction memory.
REQ-006 Port: imem_addr  output  32  fetch address; equals the current PC.
REQ-007 Port: imem_valid  input  1  memory response strobe; arrives at least 1 cycle after imem_req; at most one request is outstanding.
REQ-008 Port: imem_rdata  input  32  instruction word; sampled only when imem_valid=1.
REQ-009 Port: instr_ready  input  1  decode stage accepts instr this cycle.
REQ-010 Port: redirect_valid  input  1  branch or jump taken; load redirect_pc.
REQ-011 Port: redirect_pc  input  32  target address; bits [1:0] are forced to 2'b00.
REQ-012 Port: instr  output  32  fetched instruction word, registered.
REQ-013 Port: instr_valid  output  1  instr is valid for decode.
REQ-014 Port: opcode  output  7  instr[6:0]; drives the main_control opcode input.
REQ-015 Port: pc_out  output  32  PC of the instruction currently on instr.

Function
REQ-016 The FSM SHALL have exactly four states: ISSUE, WAIT, HOLD, FLUSH.
REQ-017 ISSUE: imem_req=1 and imem_addr=pc for exactly one cycle, then go to WAIT.
REQ-018 WAIT: on imem_valid, capture instr<=imem_rdata and pc_out<=pc, set instr_valid=1, and go to HOLD.
REQ-019 HOLD: instr and instr_valid are held stable while instr_ready=0.
REQ-020 HOLD: on instr_ready=1, set pc<=pc+4 (wrapping modulo 2^32), clear instr_valid, and go to ISSUE.
REQ-021 redirect_valid SHALL have priority over instr_ready and over imem_valid in every state.
REQ-022 Redirect in ISSUE or HOLD: pc<=redirect_pc, instr_valid<=0, instr<=NOP_INSTR, next state ISSUE.
REQ-023 Redirect in WAIT without imem_valid: pc<=redirect_pc, next state FLUSH; the in-flight response SHALL be discarded.
REQ-024 Redirect in WAIT with imem_valid in the same cycle: discard the response, pc<=redirect_pc, next state ISSUE.
REQ-025 FLUSH: imem_req=0; on imem_valid, discard the data and go to ISSUE; a further redirect in FLUSH updates pc and stays in FLUSH.
REQ-026 imem_req SHALL never be asserted outside ISSUE, so at most one request is ever outstanding.
REQ-027 Latency: with a 1-cycle memory, redirect or reset to instr_valid is 3 cycles; sustained throughput is 1 instruction per 3 cycles.

Reset
REQ-028 With rst_n=0, asynchronously: state=ISSUE, pc=RESET_PC, pc_out=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0.
REQ-029 The first imem_req SHALL occur in the first cycle after rst_n deasserts.
REQ-030 Reset mid-WAIT: a late imem_valid arriving after reset SHALL be ignored unless the block is in WAIT.

Structure
REQ-031 The shared package riscv_pkg SHALL hold the opcode constants (OP_RTYPE 0110011, OP_ITYPE 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111, OP_LUI 0110111), NOP_INSTR, and the fetch FSM state encoding.
REQ-032 One sub-module, fetch_pc_reg, SHALL hold the PC register with reset, +4 increment and redirect load; the FSM lives in instr_fetch.

Verification
REQ-033 Reset release, 1-cycle memory returning 32'h0000_0033 -> imem_req with addr 0x0 in cycle 1; instr_valid=1, opcode=0110011, pc_out=0x0 in cycle 3.
REQ-034 Consecutive fetches with instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid never asserted for two words at once.
REQ-035 instr_ready=0 for 5 cycles in HOLD -> instr, pc_out and instr_valid stable; no imem_req during the stall.
REQ-036 Redirect to 0x0000_0103 during WAIT, response 4 cycles later -> stale word dropped, next imem_addr=0x0000_0100, instr_valid stays 0 until the new response.
REQ-037 Redirect coincident with instr_ready in HOLD -> pc=redirect target, not pc+4; same-cycle redirect with imem_valid -> response discarded, ISSUE next cycle.
REQ-038 rst_n asserted mid-WAIT, then a late imem_valid -> outputs return to reset values immediately; the fetch restarts at RESET_PC.
